// File: rtl/cpu_defs_pkg.sv
// Shared MIPS core definitions: exception codes, reset/handler vectors and
// the stage-register operation encoding used by the pipeline registers.
package cpu_defs;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP            = 32'd0;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_ADV    = 2'd1,
    OP_BUBBLE = 2'd2,
    OP_FLUSH  = 2'd3
  } stage_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exccode;
  } slot_t;

  // The earliest stage's exception wins over one found locally.
  function automatic logic [4:0] merge_exc(input logic [4:0] carried,
                                           input logic [4:0] local_code);
    logic [4:0] merged;
    if (carried != EXC_NONE) begin
      merged = carried;
    end else begin
      merged = local_code;
    end
    return merged;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_hold_counter.sv
// Saturating count of consecutive hold cycles with a combinational hang flag
// derived directly from the registered count.
module hold_counter
  import cpu_defs::*;
#(
  parameter int CNT_W      = 8,
  parameter int HANG_LIMIT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hang_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on any non-hold cycle, otherwise increment up to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign hang_o = (cnt_q >= CNT_W'(HANG_LIMIT));

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the 5-stage MIPS core with
// bubble insertion, exception-code merging, flush-to-handler and hang detection.
module pipe_stage_reg
  import cpu_defs::*;
#(
  parameter int          PAYLOAD_W   = 32,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [31:0] HANDLER_PC  = HANDLER_PC_DEF,
  parameter bit          KILL_ON_EXC = 1'b1,
  parameter int          CNT_W       = 8,
  parameter int          HANG_LIMIT  = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 bubble,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  input  logic                 in_bd,
  input  logic [4:0]           in_exccode,
  input  logic [4:0]           local_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic                 out_bd,
  output logic [4:0]           out_exccode,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic                 hang
);

  stage_op_e            op_s;
  logic [4:0]           merged_s;
  logic                 kill_s;
  slot_t                slot_q;
  slot_t                slot_d;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [PAYLOAD_W-1:0] payload_d;

  // Resolve the cycle's operation: req > bubble > en > hold.
  always_comb begin
    op_s = OP_HOLD;
    if (req) begin
      op_s = OP_FLUSH;
    end else if (bubble) begin
      op_s = OP_BUBBLE;
    end else if (en) begin
      op_s = OP_ADV;
    end else begin
      op_s = OP_HOLD;
    end
  end

  assign merged_s = merge_exc(in_exccode, local_exc);
  assign kill_s   = KILL_ON_EXC && (merged_s != EXC_NONE);

  // Next slot contents; a bubble keeps pc/bd so EPC and BD stay right for an interrupt.
  always_comb begin
    slot_d    = slot_q;
    payload_d = payload_q;
    case (op_s)
      OP_FLUSH: begin
        slot_d    = '{valid: 1'b0, pc: HANDLER_PC, instr: NOP, bd: 1'b0, exccode: EXC_NONE};
        payload_d = {PAYLOAD_W{1'b0}};
      end
      OP_BUBBLE: begin
        slot_d    = '{valid: 1'b0, pc: in_pc, instr: NOP, bd: in_bd, exccode: EXC_NONE};
        payload_d = {PAYLOAD_W{1'b0}};
      end
      OP_ADV: begin
        slot_d.valid   = in_valid;
        slot_d.pc      = in_pc;
        slot_d.bd      = in_bd;
        slot_d.exccode = merged_s;
        if (kill_s) begin
          slot_d.instr = NOP;
          payload_d    = {PAYLOAD_W{1'b0}};
        end else begin
          slot_d.instr = in_instr;
          payload_d    = in_payload;
        end
      end
      OP_HOLD: begin
        slot_d    = slot_q;
        payload_d = payload_q;
      end
      default: begin
        slot_d    = slot_q;
        payload_d = payload_q;
      end
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '{valid: 1'b0, pc: RESET_PC, instr: NOP, bd: 1'b0, exccode: EXC_NONE};
      payload_q <= {PAYLOAD_W{1'b0}};
    end else begin
      slot_q    <= slot_d;
      payload_q <= payload_d;
    end
  end

  hold_counter #(
    .CNT_W      (CNT_W),
    .HANG_LIMIT (HANG_LIMIT)
  ) u_hold_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (op_s != OP_HOLD),
    .cnt_o  (hold_cnt),
    .hang_o (hang)
  );

  assign out_valid   = slot_q.valid;
  assign out_pc      = slot_q.pc;
  assign out_instr   = slot_q.instr;
  assign out_bd      = slot_q.bd;
  assign out_exccode = slot_q.exccode;
  assign out_payload = payload_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage register.
module tb_pipe_stage_reg;

  localparam int PW    = 32;
  localparam int CW    = 8;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          reset, req, bubble, en, in_valid, in_bd;
  logic [31:0]   in_pc, in_instr;
  logic [4:0]    in_exccode, local_exc;
  logic [PW-1:0] in_payload;
  logic          out_valid, out_bd, hang;
  logic [31:0]   out_pc, out_instr;
  logic [4:0]    out_exccode;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_valid, m_bd;
  bit [31:0]   m_pc, m_instr;
  bit [4:0]    m_exc;
  bit [PW-1:0] m_pay;
  int          m_cnt;

  pipe_stage_reg #(
    .PAYLOAD_W   (PW),
    .RESET_PC    (32'h0000_3000),
    .HANDLER_PC  (32'h0000_4180),
    .KILL_ON_EXC (1'b1),
    .CNT_W       (CW),
    .HANG_LIMIT  (LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .bubble(bubble), .en(en),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .in_exccode(in_exccode), .local_exc(local_exc), .in_payload(in_payload),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_bd(out_bd),
    .out_exccode(out_exccode), .out_payload(out_payload),
    .hold_cnt(hold_cnt), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the stage rules to the model for the inputs currently driven.
  task automatic model_update();
    bit [4:0] merged;
    if (reset) begin
      m_valid = 0; m_pc = 32'h3000; m_instr = 0; m_bd = 0; m_exc = 0; m_pay = 0; m_cnt = 0;
    end else if (req) begin
      m_valid = 0; m_pc = 32'h4180; m_instr = 0; m_bd = 0; m_exc = 0; m_pay = 0; m_cnt = 0;
    end else if (bubble) begin
      m_valid = 0; m_pc = in_pc; m_instr = 0; m_bd = in_bd; m_exc = 0; m_pay = 0; m_cnt = 0;
    end else if (en) begin
      merged  = (in_exccode != 0) ? in_exccode : local_exc;
      m_valid = in_valid; m_pc = in_pc; m_bd = in_bd; m_exc = merged; m_cnt = 0;
      m_instr = (merged != 0) ? 32'd0 : in_instr;
      m_pay   = (merged != 0) ? '0 : in_payload;
    end else begin
      m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"},   64'(out_valid),   64'(m_valid));
    check_eq({tag, ".pc"},      64'(out_pc),      64'(m_pc));
    check_eq({tag, ".instr"},   64'(out_instr),   64'(m_instr));
    check_eq({tag, ".bd"},      64'(out_bd),      64'(m_bd));
    check_eq({tag, ".exc"},     64'(out_exccode), 64'(m_exc));
    check_eq({tag, ".payload"}, 64'(out_payload), 64'(m_pay));
    check_eq({tag, ".cnt"},     64'(hold_cnt),    64'(m_cnt));
    check_eq({tag, ".hang"},    64'(hang),        64'(m_cnt >= LIMIT));
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic drive(input bit r, input bit q, input bit b, input bit e, input bit v,
                       input logic [31:0] pc, input logic [31:0] ins, input bit bd,
                       input logic [4:0] ie, input logic [4:0] le, input logic [PW-1:0] pl);
    reset = r; req = q; bubble = b; en = e; in_valid = v; in_pc = pc;
    in_instr = ins; in_bd = bd; in_exccode = ie; local_exc = le; in_payload = pl;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 5'd0, '0);
    @(negedge clk);

    // Reset for two cycles
    step("rst1");
    step("rst2");
    check_eq("rst_pc", 64'(out_pc), 64'h3000);
    check_eq("rst_instr", 64'(out_instr), 64'h0);
    check_eq("rst_valid", 64'(out_valid), 64'h0);

    // Plain advance
    drive(0, 0, 0, 1, 1, 32'h3004, 32'h2401_0001, 1, 5'd0, 5'd0, 32'hCAFE_0001);
    step("adv");
    check_eq("adv_instr", 64'(out_instr), 64'h2401_0001);
    check_eq("adv_pc", 64'(out_pc), 64'h3004);

    // Exception merging: carried code wins; otherwise local code is taken
    drive(0, 0, 0, 1, 1, 32'h3008, 32'h1234_5678, 0, 5'd4, 5'd10, 32'hDEAD_BEEF);
    step("merge1");
    check_eq("merge1_exc", 64'(out_exccode), 64'd4);
    check_eq("merge1_kill", 64'(out_instr), 64'h0);
    drive(0, 0, 0, 1, 1, 32'h300C, 32'h1111_2222, 0, 5'd0, 5'd12, 32'h5555_AAAA);
    step("merge2");
    check_eq("merge2_exc", 64'(out_exccode), 64'd12);

    // Invalid slot still captured, with merged exception
    drive(0, 0, 0, 1, 0, 32'h3020, 32'h0BAD_F00D, 1, 5'd0, 5'd5, 32'h1);
    step("inval");
    check_eq("inval_pc", 64'(out_pc), 64'h3020);

    // Bubble beats en, keeps pc/bd
    drive(0, 0, 1, 1, 1, 32'h3010, 32'hFFFF_FFFF, 1, 5'd4, 5'd4, 32'h77);
    step("bubble");
    check_eq("bubble_pc", 64'(out_pc), 64'h3010);
    check_eq("bubble_bd", 64'(out_bd), 64'h1);

    // req beats bubble and en
    drive(0, 1, 1, 1, 1, 32'h3014, 32'h1, 1, 5'd0, 5'd0, 32'h99);
    step("req");
    check_eq("req_pc", 64'(out_pc), 64'h4180);

    // Hold until hang, then saturate, then release
    drive(0, 0, 0, 0, 1, 32'h3018, 32'h2, 1, 5'd0, 5'd0, 32'h3);
    for (int i = 0; i < 3; i++) step("hold");
    check_eq("hang_cnt3", 64'(hold_cnt), 64'd3);
    check_eq("hang_set", 64'(hang), 64'h1);
    for (int i = 0; i < 297; i++) step("hold_sat");
    check_eq("sat_cnt", 64'(hold_cnt), 64'd255);
    drive(0, 0, 0, 1, 1, 32'h3018, 32'h2, 1, 5'd0, 5'd0, 32'h3);
    step("release");
    check_eq("release_cnt", 64'(hold_cnt), 64'd0);
    check_eq("release_hang", 64'(hang), 64'h0);

    // Reset in the middle of a hold run
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 5'd0, '0);
    for (int i = 0; i < 5; i++) step("prehold");
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0, 5'd0, '0);
    step("midrst");

    // Randomized traffic; holds are frequent so hang is exercised too
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      drive(sel < 2, (sel >= 2 && sel < 7), (sel >= 7 && sel < 20), (sel >= 15 && sel < 60),
            $urandom_range(0, 1) != 0, $urandom, $urandom, $urandom_range(0, 1) != 0,
            ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0,
            ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0, $urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
